lcd_frame_capture: RTL and testbench

- Receive end of the RGB LCD interface: samples VSYNC/DE/PIXEL_DATA, packs pixel pairs into 32-bit words, buffers them, writes whole frames to memory via DMA write bursts.
- Frame-grabber/loopback counterpart to the LCD scan-out path; used to capture the controller's own output or an external RGB source into a frame buffer.
- Single clock domain; pixel interface and DMA interface both run on CLK.

---
 rtl/lcd_capture_pkg.sv | 24 ++
 rtl/lcd_capture_fifo.sv | 59 +++++
 rtl/lcd_frame_capture.sv | 173 +++++++++++++++++
 tb/tb_lcd_frame_capture.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_capture_pkg.sv
// Shared types and sizing helpers for the LCD frame capture block.
package lcd_capture_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int unsigned ADDR_W = 29;
  localparam int unsigned PIX_W  = 16;
  localparam int unsigned WORD_W = 32;

  function automatic int unsigned frame_words(input int unsigned h, input int unsigned v);
    return (h * v) / 2;
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Word count of a frame at the default 800x480 geometry.
  localparam int unsigned FRAME_WORDS = frame_words(800, 480);

endpackage

// File: rtl/lcd_capture_fifo.sv
// First-word-fall-through word FIFO with synchronous flush.
module lcd_capture_fifo
  import lcd_capture_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW = ptr_width(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rptr];
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + AW'(1);
      end
      if (do_pop) rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lcd_frame_capture.sv
// RGB LCD receive path: packs pixel pairs into words and writes frames out in DMA bursts.
module lcd_frame_capture
  import lcd_capture_pkg::*;
#(
  parameter int unsigned BURST_SIZE     = 8,
  parameter int unsigned HPIXELS        = 800,
  parameter int unsigned VPIXELS        = 480,
  parameter int unsigned FIFO_DEPTH     = 32,
  parameter bit          VSYNC_POLARITY = 1'b0,
  parameter int unsigned Y_BITS         = 10
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              ENABLE,
  input  logic              VSYNC,
  input  logic              DE,
  input  logic [PIX_W-1:0]  PIXEL_DATA,
  input  logic [ADDR_W-1:0] BUFFER_START_ADDRESS,
  output logic [ADDR_W-1:0] DMA_WR_ADDR,
  output logic              DMA_START,
  input  logic              DMA_READY,
  output logic [WORD_W-1:0] DMA_WR_DATA,
  input  logic              DMA_WR_DATA_REQ,
  output logic [Y_BITS-1:0] ROW_INDEX,
  output logic              FRAME_DONE,
  output logic              OVERFLOW
);

  localparam int unsigned FRAME_LEN = frame_words(HPIXELS, VPIXELS);
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);
  localparam int unsigned FCNT_W    = ptr_width(FIFO_DEPTH) + 1;
  localparam int unsigned BEAT_W    = $clog2(BURST_SIZE + 1);

  state_t              state;
  logic                vs_act_q;
  logic                de_q;
  logic                armed;
  logic                pending;
  logic                pend_enable;
  logic [ADDR_W-1:0]   pend_addr;
  logic [ADDR_W-1:0]   ptr;
  logic                phase;
  logic [PIX_W-1:0]    lo_q;
  logic [WORD_W-1:0]   word_q;
  logic                push_q;
  logic [CNT_W-1:0]    word_cnt;
  logic [CNT_W-1:0]    issued_cnt;
  logic [BEAT_W-1:0]   beats_left;
  logic [FCNT_W-1:0]   fifo_count;
  logic                fifo_full;

  logic vs_act, start, hold, apply, burst_last, take_pix, pop, launch, drop;

  assign vs_act     = (VSYNC == VSYNC_POLARITY);
  assign start      = vs_act && !vs_act_q;
  assign hold       = start || pending;
  assign burst_last = (state == BURST) && DMA_WR_DATA_REQ && (beats_left == BEAT_W'(1));
  // A frame start waits for any burst in flight so the DMA never sees a torn burst.
  assign apply      = hold && ((state == IDLE) || burst_last);
  assign take_pix   = armed && !hold && DE && (word_cnt < CNT_W'(FRAME_LEN));
  assign pop        = (state == BURST) && DMA_WR_DATA_REQ;
  assign launch     = (state == IDLE) && !apply && DMA_READY &&
                      (fifo_count >= FCNT_W'(BURST_SIZE));
  assign drop       = push_q && fifo_full && !pop;

  lcd_capture_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESETN),
    .push  (push_q),
    .pop   (pop),
    .flush (apply),
    .wdata (word_q),
    .rdata (DMA_WR_DATA),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Frame tracking, pixel packing and row counting.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      vs_act_q    <= 1'b1;
      de_q        <= 1'b0;
      armed       <= 1'b0;
      pending     <= 1'b0;
      pend_enable <= 1'b0;
      pend_addr   <= '0;
      phase       <= 1'b0;
      lo_q        <= '0;
      word_q      <= '0;
      push_q      <= 1'b0;
      word_cnt    <= '0;
      ROW_INDEX   <= '0;
      OVERFLOW    <= 1'b0;
    end else begin
      vs_act_q <= vs_act;
      de_q     <= DE;
      push_q   <= 1'b0;
      if (start) begin
        pend_enable <= ENABLE;
        pend_addr   <= BUFFER_START_ADDRESS;
      end
      if (apply) begin
        pending   <= 1'b0;
        armed     <= start ? ENABLE : pend_enable;
        phase     <= 1'b0;
        word_cnt  <= '0;
        ROW_INDEX <= '0;
        OVERFLOW  <= 1'b0;
      end else begin
        if (start) pending <= 1'b1;
        if (take_pix) begin
          phase <= ~phase;
          if (!phase) begin
            lo_q <= PIXEL_DATA;
          end else begin
            word_q   <= {PIXEL_DATA, lo_q};
            push_q   <= 1'b1;
            word_cnt <= word_cnt + CNT_W'(1);
          end
        end
        if (armed && !hold && de_q && !DE && (ROW_INDEX != Y_BITS'(VPIXELS)))
          ROW_INDEX <= ROW_INDEX + Y_BITS'(1);
        if (drop) OVERFLOW <= 1'b1;
      end
    end
  end

  // Burst sequencer and frame-buffer write pointer.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state       <= IDLE;
      ptr         <= '0;
      DMA_START   <= 1'b0;
      DMA_WR_ADDR <= '0;
      beats_left  <= '0;
      issued_cnt  <= '0;
      FRAME_DONE  <= 1'b0;
    end else begin
      DMA_START  <= 1'b0;
      FRAME_DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            state       <= BURST;
            DMA_START   <= 1'b1;
            DMA_WR_ADDR <= ptr;
            ptr         <= ptr + ADDR_W'(BURST_SIZE);
            beats_left  <= BEAT_W'(BURST_SIZE);
            issued_cnt  <= issued_cnt + CNT_W'(BURST_SIZE);
          end
        end
        BURST: begin
          if (DMA_WR_DATA_REQ) begin
            beats_left <= beats_left - BEAT_W'(1);
            if (burst_last) begin
              state      <= IDLE;
              FRAME_DONE <= armed && !apply && (issued_cnt == CNT_W'(FRAME_LEN));
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (apply) begin
        ptr        <= start ? BUFFER_START_ADDRESS : pend_addr;
        issued_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lcd_frame_capture.sv
// Directed bench for lcd_frame_capture on a 4x4 frame, 2-word bursts, 4-word FIFO.
module tb_lcd_frame_capture;

  localparam int unsigned BS = 2;
  localparam int unsigned HP = 4;
  localparam int unsigned VP = 4;
  localparam int unsigned FD = 4;

  logic        CLK;
  logic        RESETN;
  logic        ENABLE;
  logic        VSYNC;
  logic        DE;
  logic [15:0] PIXEL_DATA;
  logic [28:0] BUFFER_START_ADDRESS;
  logic [28:0] DMA_WR_ADDR;
  logic        DMA_START;
  logic        DMA_READY;
  logic [31:0] DMA_WR_DATA;
  logic        DMA_WR_DATA_REQ;
  logic [9:0]  ROW_INDEX;
  logic        FRAME_DONE;
  logic        OVERFLOW;

  int passed = 0;
  int total = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int bad_start = 0;
  int req_budget = -1;
  int req_issued = 0;
  logic [28:0] addr_q[$];
  logic [31:0] data_q[$];

  lcd_frame_capture #(
    .BURST_SIZE     (BS),
    .HPIXELS        (HP),
    .VPIXELS        (VP),
    .FIFO_DEPTH     (FD),
    .VSYNC_POLARITY (1'b0),
    .Y_BITS         (10)
  ) dut (
    .CLK                  (CLK),
    .RESETN               (RESETN),
    .ENABLE               (ENABLE),
    .VSYNC                (VSYNC),
    .DE                   (DE),
    .PIXEL_DATA           (PIXEL_DATA),
    .BUFFER_START_ADDRESS (BUFFER_START_ADDRESS),
    .DMA_WR_ADDR          (DMA_WR_ADDR),
    .DMA_START            (DMA_START),
    .DMA_READY            (DMA_READY),
    .DMA_WR_DATA          (DMA_WR_DATA),
    .DMA_WR_DATA_REQ      (DMA_WR_DATA_REQ),
    .ROW_INDEX            (ROW_INDEX),
    .FRAME_DONE           (FRAME_DONE),
    .OVERFLOW             (OVERFLOW)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1);
  end

  // DMA model: answers each DMA_START with BS back-to-back REQs, limited by req_budget.
  initial begin
    int beats;
    beats = 0;
    DMA_WR_DATA_REQ = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (!RESETN) begin
        beats = 0;
        DMA_WR_DATA_REQ = 1'b0;
      end else begin
        if (DMA_START) beats = BS;
        if (beats > 0 && (req_budget < 0 || req_issued < req_budget)) begin
          DMA_WR_DATA_REQ = 1'b1;
          beats--;
          req_issued++;
        end else begin
          DMA_WR_DATA_REQ = 1'b0;
        end
      end
    end
  end

  // Record bursts, consumed words and frame completions on the falling edge.
  initial begin
    forever begin
      @(negedge CLK);
      if (RESETN) begin
        if (DMA_START) begin
          start_cnt++;
          addr_q.push_back(DMA_WR_ADDR);
          if (!DMA_READY) bad_start++;
        end
        if (DMA_WR_DATA_REQ) data_q.push_back(DMA_WR_DATA);
        if (FRAME_DONE) done_cnt++;
      end
    end
  end

  function automatic logic [28:0] addr_at(input int i);
    if (i < addr_q.size()) return addr_q[i];
    return 'x;
  endfunction

  function automatic logic [31:0] data_at(input int i);
    if (i < data_q.size()) return data_q[i];
    return 'x;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic vsync_pulse();
    VSYNC = 1'b0;
    step();
    step();
    VSYNC = 1'b1;
    step();
  endtask

  task automatic send_lines(input logic [15:0] first, input int n);
    logic [15:0] pix;
    pix = first;
    for (int l = 0; l < n; l++) begin
      for (int p = 0; p < int'(HP); p++) begin
        DE = 1'b1;
        PIXEL_DATA = pix;
        pix = pix + 16'd1;
        step();
      end
      DE = 1'b0;
      PIXEL_DATA = '0;
      step();
      step();
    end
  endtask

  task automatic wait_req(input int target);
    for (int i = 0; i < 60 && req_issued < target; i++) step();
  endtask

  task automatic test_reset();
    int s_s;
    s_s = start_cnt;
    #1;
    total++; if (DMA_WR_ADDR !== 29'd0) $display("FAIL rst_addr: got %h want 0", DMA_WR_ADDR); else passed++;
    total++; if (DMA_WR_DATA !== 32'd0) $display("FAIL rst_data: got %h want 0", DMA_WR_DATA); else passed++;
    total++; if (DMA_START !== 1'b0) $display("FAIL rst_start: got %b want 0", DMA_START); else passed++;
    idle(3);
    RESETN = 1'b1;
    idle(10);
    total++; if (ROW_INDEX !== 10'd0) $display("FAIL idle_row: got %0d want 0", ROW_INDEX); else passed++;
    total++; if (FRAME_DONE !== 1'b0 || OVERFLOW !== 1'b0)
      $display("FAIL idle_flags: got done=%b ovf=%b want 0 0", FRAME_DONE, OVERFLOW); else passed++;
    total++; if (start_cnt - s_s !== 0) $display("FAIL idle_nostart: got %0d starts want 0", start_cnt - s_s); else passed++;
  endtask

  task automatic test_small_frame();
    int s_a, s_d, s_s, s_f;
    logic [31:0] exp;
    s_a = addr_q.size(); s_d = data_q.size(); s_s = start_cnt; s_f = done_cnt;
    ENABLE = 1'b1;
    DMA_READY = 1'b1;
    BUFFER_START_ADDRESS = 29'h100;
    vsync_pulse();
    send_lines(16'h0001, 4);
    idle(30);
    total++; if (start_cnt - s_s !== 4) $display("FAIL small_starts: got %0d want 4", start_cnt - s_s); else passed++;
    for (int b = 0; b < 4; b++) begin
      total++;
      if (addr_at(s_a + b) !== 29'h100 + 29'(2 * b))
        $display("FAIL small_addr%0d: got %h want %h", b, addr_at(s_a + b), 29'h100 + 29'(2 * b));
      else passed++;
    end
    for (int k = 0; k < 8; k++) begin
      exp = {16'(2 * k + 2), 16'(2 * k + 1)};
      total++;
      if (data_at(s_d + k) !== exp) $display("FAIL small_word%0d: got %h want %h", k, data_at(s_d + k), exp);
      else passed++;
    end
    total++; if (done_cnt - s_f !== 1) $display("FAIL small_done: got %0d want 1", done_cnt - s_f); else passed++;
    total++; if (ROW_INDEX !== 10'd4) $display("FAIL small_row: got %0d want 4", ROW_INDEX); else passed++;
    total++; if (OVERFLOW !== 1'b0) $display("FAIL small_ovf: got %b want 0", OVERFLOW); else passed++;
  endtask

  task automatic test_backpressure();
    int s_a, s_d, s_s, s_f;
    s_a = addr_q.size(); s_d = data_q.size(); s_s = start_cnt; s_f = done_cnt;
    DMA_READY = 1'b0;
    BUFFER_START_ADDRESS = 29'h200;
    vsync_pulse();
    send_lines(16'h0101, 4);
    idle(4);
    total++; if (OVERFLOW !== 1'b1) $display("FAIL bp_ovf_set: got %b want 1", OVERFLOW); else passed++;
    total++; if (start_cnt - s_s !== 0) $display("FAIL bp_held: got %0d starts want 0", start_cnt - s_s); else passed++;
    send_lines(16'h0181, 1);
    DMA_READY = 1'b1;
    idle(30);
    total++; if (start_cnt - s_s !== 2) $display("FAIL bp_starts: got %0d want 2", start_cnt - s_s); else passed++;
    total++; if (addr_at(s_a + 1) !== 29'h202) $display("FAIL bp_addr1: got %h want 202", addr_at(s_a + 1)); else passed++;
    total++; if (data_at(s_d) !== 32'h01020101) $display("FAIL bp_word0: got %h want 01020101", data_at(s_d)); else passed++;
    total++; if (data_at(s_d + 3) !== 32'h01080107) $display("FAIL bp_word3: got %h want 01080107", data_at(s_d + 3)); else passed++;
    total++; if (done_cnt - s_f !== 0) $display("FAIL bp_done: got %0d want 0", done_cnt - s_f); else passed++;
    total++; if (OVERFLOW !== 1'b1) $display("FAIL bp_ovf_sticky: got %b want 1", OVERFLOW); else passed++;
    vsync_pulse();
    total++; if (OVERFLOW !== 1'b0) $display("FAIL bp_ovf_clear: got %b want 0", OVERFLOW); else passed++;
  endtask

  task automatic test_disabled();
    int s_a, s_d, s_s, s_f;
    s_a = addr_q.size(); s_d = data_q.size(); s_s = start_cnt; s_f = done_cnt;
    BUFFER_START_ADDRESS = 29'h280;
    ENABLE = 1'b0;
    vsync_pulse();
    send_lines(16'h0A01, 2);
    ENABLE = 1'b1;
    send_lines(16'h0A11, 2);
    idle(20);
    total++; if (start_cnt - s_s !== 0) $display("FAIL dis_starts: got %0d want 0", start_cnt - s_s); else passed++;
    total++; if (done_cnt - s_f !== 0) $display("FAIL dis_done: got %0d want 0", done_cnt - s_f); else passed++;
    total++; if (ROW_INDEX !== 10'd0) $display("FAIL dis_row: got %0d want 0", ROW_INDEX); else passed++;
    vsync_pulse();
    send_lines(16'h0201, 4);
    idle(30);
    total++; if (start_cnt - s_s !== 4) $display("FAIL dis_next_starts: got %0d want 4", start_cnt - s_s); else passed++;
    total++; if (addr_at(s_a) !== 29'h280) $display("FAIL dis_next_addr: got %h want 280", addr_at(s_a)); else passed++;
    total++; if (data_at(s_d) !== 32'h02020201) $display("FAIL dis_next_word: got %h want 02020201", data_at(s_d)); else passed++;
    total++; if (done_cnt - s_f !== 1) $display("FAIL dis_next_done: got %0d want 1", done_cnt - s_f); else passed++;
  endtask

  task automatic test_early_vsync();
    int s_a, s_d, s_s, s_f, target;
    s_a = addr_q.size(); s_d = data_q.size(); s_s = start_cnt; s_f = done_cnt;
    ENABLE = 1'b1;
    BUFFER_START_ADDRESS = 29'h300;
    vsync_pulse();
    target = req_issued + 1;
    req_budget = target;
    send_lines(16'h0011, 1);
    wait_req(target);
    total++; if (req_issued !== target) $display("FAIL early_first_req: got %0d want %0d", req_issued, target); else passed++;
    BUFFER_START_ADDRESS = 29'h400;
    vsync_pulse();
    send_lines(16'h0EE1, 1);
    req_budget = -1;
    wait_req(target + 1);
    idle(3);
    send_lines(16'h0021, 4);
    idle(30);
    total++; if (addr_at(s_a) !== 29'h300) $display("FAIL early_old_addr: got %h want 300", addr_at(s_a)); else passed++;
    total++; if (data_at(s_d + 1) !== 32'h00140013) $display("FAIL early_tail_word: got %h want 00140013", data_at(s_d + 1)); else passed++;
    total++; if (addr_at(s_a + 1) !== 29'h400) $display("FAIL early_new_addr: got %h want 400", addr_at(s_a + 1)); else passed++;
    total++; if (data_at(s_d + 2) !== 32'h00220021) $display("FAIL early_flush: got %h want 00220021", data_at(s_d + 2)); else passed++;
    total++; if (start_cnt - s_s !== 5) $display("FAIL early_starts: got %0d want 5", start_cnt - s_s); else passed++;
    total++; if (done_cnt - s_f !== 1) $display("FAIL early_done: got %0d want 1", done_cnt - s_f); else passed++;
  endtask

  task automatic test_reset_mid_burst();
    int s_a, s_d, s_s, s_f, target;
    ENABLE = 1'b1;
    BUFFER_START_ADDRESS = 29'h500;
    vsync_pulse();
    target = req_issued + 1;
    req_budget = target;
    send_lines(16'h0051, 1);
    wait_req(target);
    @(posedge CLK);
    #3;
    RESETN = 1'b0;
    #1;
    total++; if (DMA_WR_ADDR !== 29'd0) $display("FAIL mid_rst_addr: got %h want 0", DMA_WR_ADDR); else passed++;
    total++; if (DMA_WR_DATA !== 32'd0) $display("FAIL mid_rst_data: got %h want 0", DMA_WR_DATA); else passed++;
    total++; if (ROW_INDEX !== 10'd0) $display("FAIL mid_rst_row: got %0d want 0", ROW_INDEX); else passed++;
    total++; if (DMA_START !== 1'b0 || FRAME_DONE !== 1'b0 || OVERFLOW !== 1'b0)
      $display("FAIL mid_rst_flags: got start=%b done=%b ovf=%b want 0 0 0", DMA_START, FRAME_DONE, OVERFLOW);
    else passed++;
    idle(3);
    RESETN = 1'b1;
    req_budget = -1;
    idle(2);
    s_a = addr_q.size(); s_d = data_q.size(); s_s = start_cnt; s_f = done_cnt;
    BUFFER_START_ADDRESS = 29'h600;
    vsync_pulse();
    send_lines(16'h0061, 4);
    idle(30);
    total++; if (start_cnt - s_s !== 4) $display("FAIL post_rst_starts: got %0d want 4", start_cnt - s_s); else passed++;
    total++; if (addr_at(s_a) !== 29'h600) $display("FAIL post_rst_addr: got %h want 600", addr_at(s_a)); else passed++;
    total++; if (data_at(s_d) !== 32'h00620061) $display("FAIL post_rst_word: got %h want 00620061", data_at(s_d)); else passed++;
    total++; if (done_cnt - s_f !== 1) $display("FAIL post_rst_done: got %0d want 1", done_cnt - s_f); else passed++;
    total++; if (ROW_INDEX !== 10'd4) $display("FAIL post_rst_row: got %0d want 4", ROW_INDEX); else passed++;
  endtask

  initial begin
    RESETN = 1'b0;
    ENABLE = 1'b0;
    VSYNC = 1'b1;
    DE = 1'b0;
    PIXEL_DATA = '0;
    BUFFER_START_ADDRESS = '0;
    DMA_READY = 1'b1;
    test_reset();
    test_small_frame();
    test_backpressure();
    test_disabled();
    test_early_vsync();
    test_reset_mid_burst();
    total++; if (bad_start !== 0) $display("FAIL start_without_ready: got %0d want 0", bad_start); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
